// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch front end.
//   RESET_VECTOR_DEF : default PC loaded on reset
//   NOP_INSN         : canonical RISC-V NOP (addi x0,x0,0), shown on instr_o after reset
//   fetch_state_t    : fetch FSM states
//   pc_misaligned()  : true when a PC is not word aligned
package riscv_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } fetch_state_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_loop_detect.sv
// Self-loop detector for the fetch unit.
// Counts consecutive accepted instructions whose next PC equals their own PC.
// A non-looping acceptance clears the count. When the count reaches HALT_COUNT
// the sticky halted flag is set and halt_hit_o pulses for that acceptance.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   accept_i     : decode accepted the held instruction this cycle
//   same_pc_i    : next PC equals the PC of the accepted instruction
//   halt_hit_o   : this acceptance completes the HALT_COUNT-th self-loop
//   halted_o     : sticky halted flag
module fetch_loop_detect #(
    parameter int unsigned HALT_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept_i,
    input  logic same_pc_i,
    output logic halt_hit_o,
    output logic halted_o
);

    localparam int unsigned CW = $clog2(HALT_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(HALT_COUNT - 1);

    logic [CW-1:0] loop_cnt_q, loop_cnt_d;
    logic          halted_q, halted_d;
    logic          halt_hit;

    always_comb begin
        loop_cnt_d = loop_cnt_q;
        halted_d   = halted_q;
        halt_hit   = 1'b0;
        if (accept_i) begin
            if (same_pc_i) begin
                if (loop_cnt_q == LAST) begin
                    halt_hit   = 1'b1;
                    halted_d   = 1'b1;
                    loop_cnt_d = CW'(HALT_COUNT);
                end else begin
                    loop_cnt_d = loop_cnt_q + 1'b1;
                end
            end else begin
                loop_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            loop_cnt_q <= loop_cnt_d;
            halted_q   <= halted_d;
        end
    end

    assign halt_hit_o = halt_hit;
    assign halted_o   = halted_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch unit.
// Holds the architectural PC, fetches one instruction at a time from
// instruction memory (req/ready then rvalid), presents it to decode and, when
// decode accepts, loads the downstream-computed next PC and fetches again.
// A misaligned next PC or a detected self-loop halts fetching until reset.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   next_pc_i                    : next PC, sampled when decode accepts
//   imem_req_o, imem_addr_o      : fetch request and address (= pc_o)
//   imem_ready_i                 : memory accepts the request
//   imem_rvalid_i, imem_rdata_i  : read response
//   instr_valid_o, instr_o, pc_o : instruction presented to decode
//   instr_ready_i                : decode consumes the instruction
//   misalign_o, halted_o         : sticky stop causes
//   fetch_cnt_o                  : accepted instruction count (wraps)
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int unsigned HALT_COUNT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    output logic        misalign_o,
    output logic        halted_o,
    output logic [31:0] fetch_cnt_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  cnt_q, cnt_d;

    logic accept;
    logic halt_hit;
    logic halted;

    assign accept = (state_q == HOLD) && instr_ready_i;

    fetch_loop_detect #(
        .HALT_COUNT (HALT_COUNT)
    ) u_loop_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept_i   (accept),
        .same_pc_i  (next_pc_i == pc_q),
        .halt_hit_o (halt_hit),
        .halted_o   (halted)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            REQ: begin
                if (imem_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    instr_d = imem_rdata_i;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready_i) begin
                    // next_pc_i is loaded even when it stops the unit, so pc_o
                    // shows the offending target.
                    pc_d    = next_pc_i;
                    cnt_d   = cnt_q + 32'd1;
                    valid_d = 1'b0;
                    if (pc_misaligned(next_pc_i)) misalign_d = 1'b1;
                    if (pc_misaligned(next_pc_i) || halt_hit) state_d = STOP;
                    else                                      state_d = REQ;
                end
            end
            STOP: begin
                state_d = STOP;
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= REQ;
            pc_q       <= RESET_VECTOR;
            instr_q    <= NOP_INSN;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req_o    = (state_q == REQ);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign misalign_o    = misalign_q;
    assign halted_o      = halted;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam int unsigned HC = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] next_pc_i = 32'd0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i = 1'b0;
    logic        misalign_o;
    logic        halted_o;
    logic [31:0] fetch_cnt_o;

    pc_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .HALT_COUNT   (HC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_pc_i     (next_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .misalign_o    (misalign_o),
        .halted_o      (halted_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: what the program-visible state should be.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_mis, m_halt;
    bit          m_pend;   // memory owes a response for m_pc
    bit          m_have;   // decode is holding the instruction at m_pc
    int          m_run;    // consecutive self-loop acceptances
    int          m_dly;

    // Stimulus policy (percentages)
    int unsigned p_rdy, p_dly, p_dec, p_mis, p_loop, p_br;

    // Instruction memory image; streaming test words at 0 and 4.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_8113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic set_pol(input int unsigned rdy, input int unsigned dly, input int unsigned dec,
                           input int unsigned mis, input int unsigned lp, input int unsigned br);
        p_rdy = rdy; p_dly = dly; p_dec = dec; p_mis = mis; p_loop = lp; p_br = br;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_cnt = 32'h0; m_mis = 0; m_halt = 0;
        m_pend = 0; m_have = 0; m_run = 0; m_dly = 0;
    endtask

    // One clock: check outputs at negedge, choose inputs, advance the model
    // across the coming rising edge.
    task automatic cycle();
        bit          exp_req;
        int unsigned r;
        logic [31:0] nxt;
        @(negedge clk);
        exp_req = !(m_mis || m_halt) && !m_pend && !m_have;
        check("req",   32'(imem_req_o), 32'(exp_req));
        if (exp_req) check("addr", imem_addr_o, m_pc);
        check("valid", 32'(instr_valid_o), 32'(m_have));
        check("pc",    pc_o, m_pc);
        if (m_have) check("instr", instr_o, mem_word(m_pc));
        check("cnt",   fetch_cnt_o, m_cnt);
        check("mis",   32'(misalign_o), 32'(m_mis));
        check("halt",  32'(halted_o), 32'(m_halt));

        imem_ready_i = ($urandom_range(0, 99) < p_rdy);
        if (m_pend && m_dly == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(m_pc);
        end else if (!m_pend && $urandom_range(0, 99) < 15) begin
            imem_rvalid_i = 1'b1;           // stray response, must be ignored
            imem_rdata_i  = $urandom;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        instr_ready_i = ($urandom_range(0, 99) < p_dec);
        r = $urandom_range(0, 99);
        if (r < p_mis)                       nxt = ($urandom & ~32'h3) | 32'($urandom_range(1, 3));
        else if (r < p_mis + p_loop)         nxt = m_pc;
        else if (r < p_mis + p_loop + p_br)  nxt = $urandom & ~32'h3;
        else                                 nxt = m_pc + 32'd4;
        next_pc_i = nxt;

        if (m_pend) begin
            if (m_dly == 0) begin m_pend = 0; m_have = 1; end
            else m_dly--;
        end else if (exp_req && imem_ready_i) begin
            m_pend = 1;
            m_dly  = int'($urandom_range(0, p_dly));
        end else if (m_have && instr_ready_i) begin
            m_cnt = m_cnt + 1;
            if (nxt == m_pc) m_run++; else m_run = 0;
            if (nxt[1:0] != 2'b00) m_mis = 1;
            if (m_run == int'(HC)) m_halt = 1;
            m_pc   = nxt;
            m_have = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b1;               // late response around reset
        imem_rdata_i  = 32'hDEAD_BEEF;
        instr_ready_i = 1'b1;
        #1;
        check("rst_pc",    pc_o, 32'h0);
        check("rst_instr", instr_o, NOP);
        check("rst_valid", 32'(instr_valid_o), 32'h0);
        check("rst_cnt",   fetch_cnt_o, 32'h0);
        check("rst_mis",   32'(misalign_o), 32'h0);
        check("rst_halt",  32'(halted_o), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        set_pol(100, 0, 100, 0, 0, 0);
        reset_dut();

        // Streaming: pc 0,4,8 with back-to-back fetches
        run(8);
        check("stream_cnt", fetch_cnt_o, 32'd2);
        check("stream_pc",  pc_o, 32'h8);
        run(8);

        // Reset in the middle of an outstanding fetch
        set_pol(100, 3, 100, 0, 0, 0);
        for (int i = 0; i < 50 && !m_pend; i++) cycle();
        check("pend_reached", 32'(m_pend), 32'h1);
        reset_dut();
        run(10);

        // Backpressure then release
        set_pol(100, 0, 0, 0, 0, 0);
        run(10);
        set_pol(100, 0, 100, 0, 0, 0);
        run(6);

        // Branches
        set_pol(80, 2, 70, 0, 0, 100);
        run(40);

        // Self-loop halt, then nothing more is requested
        set_pol(100, 1, 100, 0, 100, 0);
        run(40);
        check("halt_set", 32'(halted_o), 32'h1);
        run(10);

        // Misaligned target
        reset_dut();
        set_pol(100, 0, 100, 0, 0, 0);
        run(8);
        set_pol(100, 0, 100, 100, 0, 0);
        run(15);
        check("mis_set", 32'(misalign_o), 32'h1);

        // Random episodes
        for (int e = 0; e < 40; e++) begin
            reset_dut();
            set_pol($urandom_range(30, 100), $urandom_range(0, 3), $urandom_range(20, 100),
                    $urandom_range(0, 2), $urandom_range(0, 60), $urandom_range(0, 30));
            run(int'($urandom_range(60, 150)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
